// File: rtl/dsdac_pkg.sv
// Shared helpers for the multi-channel delta-sigma DAC.
// Width and conversion helpers are constant functions so each instance sizes itself.
package dsdac_pkg;

    function automatic int acc_w(input int w);
        return w + 1;
    endfunction

    function automatic int int2_w(input int w);
        return w + 4;
    endfunction

    function automatic int cnt_w(input int div);
        return (div > 1) ? $clog2(div) : 1;
    endfunction

    // XOR mask turning an input sample into unsigned offset-binary form.
    function automatic logic [23:0] conv_mask(input int w, input bit sgn);
        logic [23:0] m;
        m = 24'(1) << (w - 1);
        return sgn ? m : 24'(0);
    endfunction

endpackage

// File: rtl/dsdac_multi_if.sv
// Frame stream into dsdac_multi: valid/ready handshake plus packed channel data.
interface dsdac_multi_if #(
    parameter int NCH = 2,
    parameter int W   = 12
);
    logic               S_VALID_i;
    logic               S_READY_o;
    logic [NCH*W-1:0]   S_DATA_i;

    modport master (output S_VALID_i, output S_DATA_i, input S_READY_o);
    modport slave  (input S_VALID_i, input S_DATA_i, output S_READY_o);
endinterface

// File: rtl/dsdac_mod.sv
// Single-channel delta-sigma modulator; first order by default,
// second-order error feedback when DSDAC_SECOND_ORDER_EN is defined.
module dsdac_mod
    import dsdac_pkg::*;
#(
    parameter int W = 12
) (
    input  logic         CLK_i,
    input  logic         RST_i,
    input  logic [W-1:0] u_i,
    output logic         dac_o
);

    logic dac_q, dac_d;

`ifdef DSDAC_SECOND_ORDER_EN
    localparam int IW = int2_w(W);
    localparam logic signed [IW-1:0] HALF = IW'(2 ** (W - 1));

    logic signed [IW-1:0] i1_q, i1_d, i2_q, i2_d;
    logic signed [IW-1:0] x, fb;
    logic                 y;

    always_comb begin
        y    = !i2_q[IW-1];
        x    = $signed({{(IW-W){1'b0}}, u_i}) - HALF;
        fb   = y ? HALF : -HALF;
        i1_d = i1_q + x - fb;
        i2_d = i2_q + i1_q - fb;
        dac_d = y;
    end

    always_ff @(posedge CLK_i) begin
        if (RST_i) begin
            i1_q  <= '0;
            i2_q  <= '0;
            dac_q <= 1'b0;
        end else begin
            i1_q  <= i1_d;
            i2_q  <= i2_d;
            dac_q <= dac_d;
        end
    end
`else
    localparam int AW = acc_w(W);

    logic [W-1:0]  acc_q, acc_d;
    logic [AW-1:0] sum;

    // Carry out of the accumulator is the density bit.
    always_comb begin
        sum   = {1'b0, acc_q} + {1'b0, u_i};
        acc_d = sum[W-1:0];
        dac_d = sum[W];
    end

    always_ff @(posedge CLK_i) begin
        if (RST_i) begin
            acc_q <= '0;
            dac_q <= 1'b0;
        end else begin
            acc_q <= acc_d;
            dac_q <= dac_d;
        end
    end
`endif

    assign dac_o = dac_q;

endmodule

// File: rtl/dsdac_multi.sv
// Multi-channel delta-sigma DAC: one-deep frame buffer, sample tick, NCH modulators.
// Define DSDAC_SECOND_ORDER_EN for second-order modulators.
module dsdac_multi
    import dsdac_pkg::*;
#(
    parameter int NCH       = 2,
    parameter int W         = 12,
    parameter int DIV       = 256,
    parameter int SIGNED_IN = 0
) (
    input  logic           CLK_i,
    input  logic           RST_i,
    dsdac_multi_if.slave   s,
    output logic           TICK_o,
    output logic           UNDERRUN_o,
    output logic [NCH-1:0] DAC_o
);

    localparam int CW = cnt_w(DIV);
    localparam logic [CW-1:0] LAST = CW'(DIV - 1);
    localparam logic [W-1:0]  MID  = {1'b1, {(W-1){1'b0}}};
    localparam logic [W-1:0]  MASK = W'(conv_mask(W, SIGNED_IN != 0));

    logic [CW-1:0]    cnt_q, cnt_d;
    logic             tick;
    logic             tick_q, tick_d;
    logic             und_q, und_d;
    logic             pend_full_q, pend_full_d;
    logic             ready_q, ready_d;
    logic [NCH*W-1:0] pend_q, pend_d;
    logic [NCH*W-1:0] act_q, act_d;

    always_comb begin
        tick        = (cnt_q == LAST);
        cnt_d       = tick ? '0 : cnt_q + CW'(1);
        tick_d      = tick;
        und_d       = tick && !pend_full_q;
        pend_d      = pend_q;
        act_d       = act_q;
        pend_full_d = pend_full_q;
        // A frame arriving in an empty tick cycle waits for the next tick.
        if (tick && pend_full_q) begin
            act_d       = pend_q;
            pend_full_d = 1'b0;
        end else if (s.S_VALID_i && ready_q) begin
            pend_d      = s.S_DATA_i ^ {NCH{MASK}};
            pend_full_d = 1'b1;
        end
        ready_d = !pend_full_d;
    end

    always_ff @(posedge CLK_i) begin
        if (RST_i) begin
            cnt_q       <= '0;
            tick_q      <= 1'b0;
            und_q       <= 1'b0;
            pend_full_q <= 1'b0;
            ready_q     <= 1'b1;
            pend_q      <= '0;
            act_q       <= {NCH{MID}};
        end else begin
            cnt_q       <= cnt_d;
            tick_q      <= tick_d;
            und_q       <= und_d;
            pend_full_q <= pend_full_d;
            ready_q     <= ready_d;
            pend_q      <= pend_d;
            act_q       <= act_d;
        end
    end

    assign s.S_READY_o = ready_q;
    assign TICK_o      = tick_q;
    assign UNDERRUN_o  = und_q;

    for (genvar k = 0; k < NCH; k++) begin : g_ch
        dsdac_mod #(.W(W)) u_mod (
            .CLK_i (CLK_i),
            .RST_i (RST_i),
            .u_i   (act_q[k*W +: W]),
            .dac_o (DAC_o[k])
        );
    end

endmodule

// File: tb/tb_dsdac_multi.sv
// Randomized bench for dsdac_multi against a cycle-level behavioural model.
module tb_dsdac_multi;

    localparam int W = 8;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       tick0, und0, tick1, und1;
    logic [1:0] dac0;
    logic [0:0] dac1;

    dsdac_multi_if #(.NCH(2), .W(W)) if0 ();
    dsdac_multi_if #(.NCH(1), .W(W)) if1 ();

    dsdac_multi #(.NCH(2), .W(W), .DIV(16), .SIGNED_IN(0)) dut0 (
        .CLK_i(clk), .RST_i(rst), .s(if0),
        .TICK_o(tick0), .UNDERRUN_o(und0), .DAC_o(dac0)
    );

    dsdac_multi #(.NCH(1), .W(W), .DIV(12), .SIGNED_IN(1)) dut1 (
        .CLK_i(clk), .RST_i(rst), .s(if1),
        .TICK_o(tick1), .UNDERRUN_o(und1), .DAC_o(dac1)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
        end
    endtask

    int divs[2] = '{16, 12};
    int nchs[2] = '{2, 1};
    bit sgn[2]  = '{1'b0, 1'b1};

    int cnt[2];
    bit pf[2];
    int pend[2][2];
    int act[2][2];
    int acc[2][2];
    int i1[2][2];
    int i2[2][2];
    bit e_dac[2][2];
    bit e_tick[2];
    bit e_und[2];

    task automatic model(input int d, input bit r, input bit v,
                         input int da, input int db);
        int data[2];
        bit tk;
        data[0] = da;
        data[1] = db;
        if (r) begin
            cnt[d] = 0;
            pf[d] = 1'b0;
            e_tick[d] = 1'b0;
            e_und[d] = 1'b0;
            for (int k = 0; k < 2; k++) begin
                act[d][k] = 128;
                acc[d][k] = 0;
                i1[d][k] = 0;
                i2[d][k] = 0;
                e_dac[d][k] = 1'b0;
            end
        end else begin
            tk = (cnt[d] == divs[d] - 1);
            for (int k = 0; k < nchs[d]; k++) begin
`ifdef DSDAC_SECOND_ORDER_EN
                int fb, old1;
                fb = (i2[d][k] >= 0) ? 128 : -128;
                e_dac[d][k] = (i2[d][k] >= 0);
                old1 = i1[d][k];
                i1[d][k] = i1[d][k] + act[d][k] - 128 - fb;
                i2[d][k] = i2[d][k] + old1 - fb;
`else
                int sm;
                sm = acc[d][k] + act[d][k];
                e_dac[d][k] = (sm >= 256);
                acc[d][k] = sm % 256;
`endif
            end
            e_tick[d] = tk;
            e_und[d] = tk && !pf[d];
            if (tk && pf[d]) begin
                for (int k = 0; k < 2; k++) act[d][k] = pend[d][k];
                pf[d] = 1'b0;
            end else if (v && !pf[d]) begin
                for (int k = 0; k < 2; k++)
                    pend[d][k] = sgn[d] ? (data[k] ^ 128) : data[k];
                pf[d] = 1'b1;
            end
            cnt[d] = (cnt[d] + 1) % divs[d];
        end
    endtask

    task automatic cyc(input bit r, input bit v0, input int a0, input int b0,
                       input bit v1, input int a1);
        rst = r;
        if0.S_VALID_i = v0;
        if0.S_DATA_i = {b0[7:0], a0[7:0]};
        if1.S_VALID_i = v1;
        if1.S_DATA_i = a1[7:0];
        @(posedge clk);
        model(0, r, v0, a0, b0);
        model(1, r, v1, a1, 0);
        #1;
        check("dac0_ch0", 32'(dac0[0]), 32'(e_dac[0][0]));
        check("dac0_ch1", 32'(dac0[1]), 32'(e_dac[0][1]));
        check("tick0", 32'(tick0), 32'(e_tick[0]));
        check("und0", 32'(und0), 32'(e_und[0]));
        check("ready0", 32'(if0.S_READY_o), 32'(!pf[0]));
        check("dac1", 32'(dac1[0]), 32'(e_dac[1][0]));
        check("tick1", 32'(tick1), 32'(e_tick[1]));
        check("und1", 32'(und1), 32'(e_und[1]));
        check("ready1", 32'(if1.S_READY_o), 32'(!pf[1]));
    endtask

    task automatic idle();
        cyc(1'b0, 1'b0, 0, 0, 1'b0, 0);
    endtask

    initial begin
        int ones0, ones1, onesb;
        bit found;
        if0.S_VALID_i = 1'b0;
        if0.S_DATA_i = '0;
        if1.S_VALID_i = 1'b0;
        if1.S_DATA_i = '0;

        cyc(1'b1, 1'b0, 0, 0, 1'b0, 0);
        cyc(1'b1, 1'b0, 0, 0, 1'b0, 0);
        check("reset_ready0", 32'(if0.S_READY_o), 32'd1);

        // idle after reset: 50% density, underrun at every tick
        repeat (40) idle();

        // full-scale / zero frame, and signed -128 on dut1
        cyc(1'b0, 1'b1, 8'hFF, 8'h00, 1'b1, 8'h80);
        repeat (40) idle();
        ones0 = 0;
        ones1 = 0;
        onesb = 0;
        for (int i = 0; i < 256; i++) begin
            idle();
            ones0 += int'(dac0[0]);
            ones1 += int'(dac0[1]);
            onesb += int'(dac1[0]);
        end
`ifndef DSDAC_SECOND_ORDER_EN
        check("density_ff", 32'(ones0), 32'd255);
        check("density_00", 32'(ones1), 32'd0);
        check("signed_m128", 32'(onesb), 32'd0);
`endif

        // back-to-back frames with valid held
        for (int i = 0; i < 60; i++)
            cyc(1'b0, 1'b1, $urandom_range(255), $urandom_range(255),
                1'b1, $urandom_range(255));

        // handshake exactly in a tick cycle with pending empty
        found = 1'b0;
        for (int i = 0; i < 100 && !found; i++) begin
            if (cnt[0] == 15 && !pf[0]) begin
                found = 1'b1;
                cyc(1'b0, 1'b1, 8'h33, 8'hCC, 1'b0, 0);
                check("tick_hs_und", 32'(und0), 32'd1);
                check("tick_hs_pend", 32'(if0.S_READY_o), 32'd0);
            end else begin
                idle();
            end
        end
        check("tick_hs_found", 32'(found), 32'd1);
        repeat (20) idle();

        // reset while a frame is pending
        cyc(1'b0, 1'b1, 8'h10, 8'h20, 1'b1, 8'h7F);
        cyc(1'b1, 1'b0, 0, 0, 1'b0, 0);
        check("rst_pend_ready", 32'(if0.S_READY_o), 32'd1);
        check("rst_pend_dac", 32'(dac0), 32'd0);
        repeat (40) idle();

        // randomized traffic with occasional resets
        for (int i = 0; i < 1500; i++)
            cyc(($urandom % 200) == 0, $urandom_range(1),
                $urandom_range(255), $urandom_range(255),
                $urandom_range(1), $urandom_range(255));

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
